seq_detect_ctrl: RTL and testbench

//  Run-time controller for serial pattern detection on the FSM/sequence-detector path.
//  - Accepts a programmable pattern (1..MAXLEN bits) and an overlap/non-overlap mode.
//  - Sequences a detection run over a valid-qualified serial bit stream.
//  - Raises Mealy match pulse z; counts matches; ends the run on match target or bit budget.

---
 rtl/seq_ctrl_pkg.sv | 18 +
 rtl/seq_match_core.sv | 52 +++++
 rtl/seq_detect_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared types, default sizes and the pattern-length legality check for the
// serial sequence-detector controller.
package seq_ctrl_pkg;

   localparam int unsigned MAXLEN_DEF = 8;
   localparam int unsigned CNTW_DEF   = 16;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   function automatic logic len_ok(input int unsigned len, input int unsigned maxlen);
      return (len >= 1) && (len <= maxlen);
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// Shift history of received bits plus fill level, compared against the
// pattern under a length mask. match is combinational on the incoming bit.
module seq_match_core
   import seq_ctrl_pkg::*;
#(
   parameter int unsigned MAXLEN = MAXLEN_DEF,
   parameter int unsigned LENW   = $clog2(MAXLEN) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shift,
   input  logic              clear,
   input  logic              x,
   input  logic [LENW-1:0]   len,
   input  logic [MAXLEN-1:0] pattern,
   output logic              match
);

   logic [MAXLEN-1:0] hist_q, hist_d, nh, mask;
   logic [LENW-1:0]   fill_q, fill_d, fill_inc;

   always_comb begin
      nh       = {hist_q[MAXLEN-2:0], x};
      fill_inc = (fill_q == LENW'(MAXLEN)) ? fill_q : fill_q + LENW'(1);
      for (int i = 0; i < MAXLEN; i++) begin
         mask[i] = (LENW'(i) < len);
      end
      // Only the newest len bits take part; older history is masked off.
      match = (fill_inc >= len) && (((nh ^ pattern) & mask) == '0);

      hist_d = hist_q;
      fill_d = fill_q;
      if (clear) begin
         hist_d = '0;
         fill_d = '0;
      end else if (shift) begin
         hist_d = nh;
         fill_d = fill_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller for serial pattern detection: config handshake, IDLE/RUN/DONE
// sequencing, saturating match/bit counters and target/budget termination.
module seq_detect_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int unsigned MAXLEN = MAXLEN_DEF,
   parameter int unsigned CNTW   = CNTW_DEF,
   parameter int unsigned LENW   = $clog2(MAXLEN) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [MAXLEN-1:0] cfg_pattern,
   input  logic [LENW-1:0]   cfg_len,
   input  logic              cfg_overlap,
   input  logic [CNTW-1:0]   cfg_target,
   input  logic [CNTW-1:0]   cfg_budget,
   output logic              cfg_err,
   input  logic              start,
   input  logic              abort,
   input  logic              x_valid,
   input  logic              x,
   output logic              z,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [CNTW-1:0]   match_count,
   output logic [CNTW-1:0]   bit_count
);

   state_e            state_q, state_d;
   logic              cfg_loaded_q, cfg_loaded_d;
   logic [MAXLEN-1:0] pattern_q, pattern_d;
   logic [LENW-1:0]   len_q, len_d;
   logic              overlap_q, overlap_d;
   logic [CNTW-1:0]   target_q, target_d;
   logic [CNTW-1:0]   budget_q, budget_d;
   logic [CNTW-1:0]   match_count_q, match_count_d;
   logic [CNTW-1:0]   bit_count_q, bit_count_d;
   logic              timeout_q, timeout_d;
   logic              cfg_err_q, cfg_err_d;

   logic shift, raw_match, hit, hs, run_start, core_clear, tgt_hit, bud_hit;

   assign cfg_ready  = (state_q == StIdle) || (state_q == StDone);
   assign hs         = cfg_valid && cfg_ready;
   assign run_start  = cfg_ready && !cfg_valid && start && cfg_loaded_q;
   assign shift      = (state_q == StRun) && x_valid && !abort;
   assign hit        = shift && raw_match;
   // Non-overlapping mode restarts the history after every match.
   assign core_clear = run_start || (hit && !overlap_q);
   assign tgt_hit    = hit && (target_q != '0) &&
                       ((CNTW+1)'(match_count_q) + (CNTW+1)'(1) == (CNTW+1)'(target_q));
   assign bud_hit    = shift && (budget_q != '0) &&
                       ((CNTW+1)'(bit_count_q) + (CNTW+1)'(1) == (CNTW+1)'(budget_q));

   seq_match_core #(
      .MAXLEN (MAXLEN),
      .LENW   (LENW)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .shift   (shift),
      .clear   (core_clear),
      .x       (x),
      .len     (len_q),
      .pattern (pattern_q),
      .match   (raw_match)
   );

   always_comb begin
      state_d       = state_q;
      cfg_loaded_d  = cfg_loaded_q;
      pattern_d     = pattern_q;
      len_d         = len_q;
      overlap_d     = overlap_q;
      target_d      = target_q;
      budget_d      = budget_q;
      match_count_d = match_count_q;
      bit_count_d   = bit_count_q;
      timeout_d     = timeout_q;
      cfg_err_d     = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (hs) begin
               if (!len_ok(32'(cfg_len), MAXLEN)) begin
                  cfg_err_d = 1'b1;
               end else begin
                  pattern_d    = cfg_pattern;
                  len_d        = cfg_len;
                  overlap_d    = cfg_overlap;
                  target_d     = cfg_target;
                  budget_d     = cfg_budget;
                  cfg_loaded_d = 1'b1;
                  state_d      = StIdle;
                  timeout_d    = 1'b0;
               end
            end else if (run_start) begin
               state_d       = StRun;
               match_count_d = '0;
               bit_count_d   = '0;
               timeout_d     = 1'b0;
            end
         end
         StRun: begin
            if (abort) begin
               state_d = StIdle;
            end else if (shift) begin
               if (bit_count_q != '1) bit_count_d = bit_count_q + CNTW'(1);
               if (hit && (match_count_q != '1)) match_count_d = match_count_q + CNTW'(1);
               if (tgt_hit) begin
                  state_d   = StDone;
                  timeout_d = 1'b0;
               end else if (bud_hit) begin
                  state_d   = StDone;
                  timeout_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cfg_loaded_q  <= 1'b0;
         pattern_q     <= '0;
         len_q         <= '0;
         overlap_q     <= 1'b0;
         target_q      <= '0;
         budget_q      <= '0;
         match_count_q <= '0;
         bit_count_q   <= '0;
         timeout_q     <= 1'b0;
         cfg_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cfg_loaded_q  <= cfg_loaded_d;
         pattern_q     <= pattern_d;
         len_q         <= len_d;
         overlap_q     <= overlap_d;
         target_q      <= target_d;
         budget_q      <= budget_d;
         match_count_q <= match_count_d;
         bit_count_q   <= bit_count_d;
         timeout_q     <= timeout_d;
         cfg_err_q     <= cfg_err_d;
      end
   end

   assign z           = hit;
   assign busy        = (state_q == StRun);
   assign done        = (state_q == StDone);
   assign timeout     = timeout_q;
   assign cfg_err     = cfg_err_q;
   assign match_count = match_count_q;
   assign bit_count   = bit_count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed tables and sequences plus
// randomized traffic against a queue-based behavioural model.
module tb_seq_detect_ctrl;

   logic        clk = 1'b0;
   logic        rst, cfg_valid, cfg_ready, cfg_overlap, cfg_err;
   logic [7:0]  cfg_pattern;
   logic [3:0]  cfg_len;
   logic [15:0] cfg_target, cfg_budget, match_count, bit_count;
   logic        start, abort, x_valid, x, z, busy, done, timeout;

   always #5 clk = ~clk;

   seq_detect_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_target  (cfg_target),
      .cfg_budget  (cfg_budget),
      .cfg_err     (cfg_err),
      .start       (start),
      .abort       (abort),
      .x_valid     (x_valid),
      .x           (x),
      .z           (z),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .match_count (match_count),
      .bit_count   (bit_count)
   );

   typedef struct packed {
      bit        rst;
      bit        cfg_valid;
      bit [7:0]  pat;
      bit [3:0]  len;
      bit        ovl;
      bit [15:0] tgt;
      bit [15:0] bud;
      bit        start;
      bit        abort;
      bit        xv;
      bit        x;
   } in_t;

   typedef struct {
      bit x;
      bit ez;
   } bit_vec_t;

   int n_vec = 0;
   int n_bad = 0;

   // Behavioural model: state 0=idle 1=run 2=done, history as a bit queue.
   int   m_state;
   bit   m_loaded, m_ovl, m_to, m_err;
   bit [7:0] m_pat;
   int   m_len, m_tgt, m_bud, m_mc, m_bc;
   bit   m_hist[$];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_loaded = 0; m_to = 0; m_err = 0;
      m_mc = 0; m_bc = 0; m_hist.delete();
   endtask

   function automatic bit model_match(input bit xb);
      bit nh[$];
      nh = m_hist;
      nh.push_back(xb);
      if (nh.size() > 8) void'(nh.pop_front());
      if (nh.size() < m_len) return 1'b0;
      for (int i = 0; i < m_len; i++) begin
         if (nh[nh.size() - 1 - i] != m_pat[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_step(input in_t v, output bit z_exp);
      bit shift, hit;
      int old_mc, old_bc;
      shift = (m_state == 1) && v.xv && !v.abort;
      hit   = shift && model_match(v.x);
      z_exp = hit;
      if (v.rst) begin
         model_reset();
         return;
      end
      m_err = 0;
      if (v.cfg_valid && m_state != 1) begin
         if (v.len == 0 || v.len > 8) begin
            m_err = 1;
         end else begin
            m_pat = v.pat; m_len = int'(v.len); m_ovl = v.ovl;
            m_tgt = int'(v.tgt); m_bud = int'(v.bud); m_loaded = 1;
            if (m_state == 2) begin m_state = 0; m_to = 0; end
         end
      end else if (m_state != 1) begin
         if (v.start && m_loaded) begin
            m_state = 1; m_mc = 0; m_bc = 0; m_to = 0; m_hist.delete();
         end
      end else if (v.abort) begin
         m_state = 0;
      end else if (shift) begin
         old_mc = m_mc; old_bc = m_bc;
         m_hist.push_back(v.x);
         if (m_hist.size() > 8) void'(m_hist.pop_front());
         if (m_bc < 65535) m_bc++;
         if (hit) begin
            if (m_mc < 65535) m_mc++;
            if (!m_ovl) m_hist.delete();
         end
         if (hit && m_tgt != 0 && old_mc + 1 == m_tgt) begin
            m_state = 2; m_to = 0;
         end else if (m_bud != 0 && old_bc + 1 == m_bud) begin
            m_state = 2; m_to = 1;
         end
      end
   endtask

   task automatic drive(input in_t v);
      rst = v.rst; cfg_valid = v.cfg_valid; cfg_pattern = v.pat; cfg_len = v.len;
      cfg_overlap = v.ovl; cfg_target = v.tgt; cfg_budget = v.bud;
      start = v.start; abort = v.abort; x_valid = v.xv; x = v.x;
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic cycle(input in_t v, output bit z_act);
      bit z_exp;
      drive(v);
      #1;
      chk("busy", int'(busy), int'(m_state == 1));
      chk("done", int'(done), int'(m_state == 2));
      chk("cfg_ready", int'(cfg_ready), int'(m_state != 1));
      chk("timeout", int'(timeout), int'(m_to));
      chk("cfg_err", int'(cfg_err), int'(m_err));
      chk("match_count", int'(match_count), m_mc);
      chk("bit_count", int'(bit_count), m_bc);
      model_step(v, z_exp);
      z_act = z;
      chk("z", int'(z), int'(z_exp));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tick(input in_t v);
      bit zz;
      cycle(v, zz);
   endtask

   task automatic do_cfg(input bit [7:0] pat, input bit [3:0] len, input bit ovl,
                         input bit [15:0] tgt, input bit [15:0] bud, input bit st);
      in_t v;
      v = '0; v.cfg_valid = 1; v.pat = pat; v.len = len; v.ovl = ovl;
      v.tgt = tgt; v.bud = bud; v.start = st;
      tick(v);
   endtask

   task automatic do_ctl(input bit st, input bit ab, input bit rs);
      in_t v;
      v = '0; v.start = st; v.abort = ab; v.rst = rs;
      tick(v);
   endtask

   task automatic send(input bit xv, input bit xb, input bit ab, output bit z_act);
      in_t v;
      v = '0; v.xv = xv; v.x = xb; v.abort = ab;
      cycle(v, z_act);
   endtask

   initial begin
      bit_vec_t t1[8], t2[8];
      bit s1[8];
      bit zo;
      int nz;
      in_t v;

      s1 = '{1, 0, 1, 0, 1, 1, 0, 1};
      for (int i = 0; i < 8; i++) begin
         t1[i].x = s1[i]; t1[i].ez = (i == 2 || i == 7);
         t2[i].x = s1[i]; t2[i].ez = (i == 2 || i == 4 || i == 7);
      end

      v = '0; v.rst = 1;
      drive(v);
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      v.rst = 0;
      drive(v);
      #1;
      chk("rst_cfg_ready", int'(cfg_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_cfg_err", int'(cfg_err), 0);
      chk("rst_z", int'(z), 0);
      chk("rst_counts", int'(match_count) + int'(bit_count), 0);
      @(negedge clk);

      // Illegal lengths, then start with nothing loaded.
      do_cfg(8'h05, 4'd0, 0, 0, 0, 0);
      chk("err_len0", int'(cfg_err), 1);
      do_cfg(8'h05, 4'd9, 0, 0, 0, 0);
      chk("err_len9", int'(cfg_err), 1);
      do_ctl(1, 0, 0);
      chk("start_unloaded", int'(busy), 0);
      do_cfg(8'h05, 4'd3, 0, 0, 0, 1);
      chk("cfg_wins_busy", int'(busy), 0);
      chk("cfg_ok_err", int'(cfg_err), 0);

      // Non-overlapping 101.
      do_ctl(1, 0, 0);
      chk("t1_busy", int'(busy), 1);
      for (int i = 0; i < 8; i++) begin
         send(1, t1[i].x, 0, zo);
         chk($sformatf("t1_z_bit%0d", i + 1), int'(zo), int'(t1[i].ez));
      end
      chk("t1_mc", int'(match_count), 2);
      chk("t1_bc", int'(bit_count), 8);
      do_ctl(0, 1, 0);

      // Overlapping 101.
      do_cfg(8'h05, 4'd3, 1, 0, 0, 0);
      do_ctl(1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         send(1, t2[i].x, 0, zo);
         chk($sformatf("t2_z_bit%0d", i + 1), int'(zo), int'(t2[i].ez));
      end
      chk("t2_mc", int'(match_count), 3);
      do_ctl(0, 1, 0);

      // Target termination.
      do_cfg(8'h05, 4'd3, 0, 16'd1, 0, 0);
      do_ctl(1, 0, 0);
      send(1, 1, 0, zo); send(1, 0, 0, zo); send(1, 1, 0, zo);
      chk("t3_done", int'(done), 1);
      chk("t3_timeout", int'(timeout), 0);
      chk("t3_mc", int'(match_count), 1);
      send(1, 0, 0, zo); send(1, 1, 0, zo);
      chk("t3_bc_held", int'(bit_count), 3);

      // Budget termination; config in DONE returns to IDLE.
      do_cfg(8'h0f, 4'd4, 0, 0, 16'd4, 0);
      chk("t3b_done_clr", int'(done), 0);
      do_ctl(1, 0, 0);
      send(1, 1, 0, zo); send(1, 0, 0, zo); send(1, 1, 0, zo); send(1, 0, 0, zo);
      chk("t3b_done", int'(done), 1);
      chk("t3b_timeout", int'(timeout), 1);
      chk("t3b_mc", int'(match_count), 0);
      chk("t3b_bc", int'(bit_count), 4);

      // Abort on the final pattern bit, then reset mid-run.
      do_cfg(8'h05, 4'd3, 0, 0, 0, 0);
      do_ctl(1, 0, 0);
      send(1, 1, 0, zo); send(1, 0, 0, zo);
      send(1, 1, 1, zo);
      chk("t5_abort_z", int'(zo), 0);
      chk("t5_abort_busy", int'(busy), 0);
      chk("t5_abort_mc", int'(match_count), 0);
      chk("t5_abort_bc", int'(bit_count), 2);
      do_ctl(1, 0, 0);
      send(1, 1, 0, zo); send(1, 0, 0, zo);
      do_ctl(0, 0, 1);
      chk("t5_rst_busy", int'(busy), 0);
      chk("t5_rst_bc", int'(bit_count), 0);
      chk("t5_rst_ready", int'(cfg_ready), 1);
      do_ctl(1, 0, 0);
      chk("t5_rst_start_ign", int'(busy), 0);

      // x_valid gaps inside the pattern.
      do_cfg(8'h05, 4'd3, 0, 0, 0, 0);
      do_ctl(1, 0, 0);
      nz = 0;
      send(1, 1, 0, zo); nz += int'(zo);
      send(0, 0, 0, zo); nz += int'(zo);
      send(1, 0, 0, zo); nz += int'(zo);
      send(0, 1, 0, zo); nz += int'(zo);
      send(0, 1, 0, zo); nz += int'(zo);
      send(1, 1, 0, zo); nz += int'(zo);
      chk("t6_gap_last_z", int'(zo), 1);
      chk("t6_gap_nz", nz, 1);
      chk("t6_gap_bc", int'(bit_count), 3);
      do_ctl(0, 1, 0);

      // len=8 overlapping on all ones.
      do_cfg(8'hff, 4'd8, 1, 0, 0, 0);
      do_ctl(1, 0, 0);
      for (int i = 0; i < 12; i++) begin
         send(1, 1, 0, zo);
         chk($sformatf("t6_len8_z_bit%0d", i + 1), int'(zo), int'(i >= 7));
      end
      chk("t6_len8_mc", int'(match_count), 5);
      do_ctl(0, 1, 0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         int r;
         v = '0;
         v.rst       = ($urandom_range(0, 399) == 0);
         v.cfg_valid = ($urandom_range(0, 19) == 0);
         r = $urandom_range(0, 19);
         v.len = (r == 0) ? 4'd0 : (r == 1) ? 4'd9 : (r < 16) ? 4'(1 + r % 3) : 4'(5 + r % 4);
         v.pat   = 8'($urandom);
         v.ovl   = 1'($urandom);
         v.tgt   = 16'($urandom_range(0, 5));
         v.bud   = 16'($urandom_range(0, 40));
         v.start = ($urandom_range(0, 9) == 0);
         v.abort = ($urandom_range(0, 59) == 0);
         v.xv    = ($urandom_range(0, 9) < 7);
         v.x     = 1'($urandom);
         tick(v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
